edge_event_arbiter: RTL

Multi-channel edge-event scheduler. It samples NUM_CH synchronous level inputs and detects enabled rising and/or falling edges per channel. Detected events are queued as one pending slot per channel and shared onto a single valid/ready event port by round-robin arbitration. It sits between the edge-detection datapath and a single downstream event consumer (interrupt/log unit) and reports dropped events.

---
 rtl/edge_event_arbiter_if.sv | 13 +
 rtl/edge_event_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/edge_event_arbiter_if.sv
// Event port between the arbiter and its single downstream consumer.
// The master presents evt_ch/evt_rise under evt_valid; the slave accepts with evt_ready.
interface edge_event_arbiter_if #(
  parameter int unsigned CH_W = 2
);
  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_ch;
  logic            evt_rise;

  modport master (output evt_valid, output evt_ch, output evt_rise, input evt_ready);
  modport slave  (input evt_valid, input evt_ch, input evt_rise, output evt_ready);
endinterface

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge detector with one pending slot per channel.
// Pending events are shared onto a single valid/ready port by round-robin arbitration.
module edge_event_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2,
  parameter int unsigned DROP_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [NUM_CH-1:0]     data_in,
  input  logic [NUM_CH-1:0]     rise_en,
  input  logic [NUM_CH-1:0]     fall_en,
  edge_event_arbiter_if.master  evt,
  output logic [NUM_CH-1:0]     overflow,
  output logic [DROP_W-1:0]     drop_cnt,
  input  logic                  clr_ovf
);

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   prev_q;
  logic [NUM_CH-1:0]   pend_q, pend_d;
  logic [NUM_CH-1:0]   pol_q, pol_d;
  logic [NUM_CH-1:0]   ovf_q, ovf_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic                rise_out_q, rise_out_d;
  logic [DROP_W-1:0]   cnt_q, cnt_d;

  logic [NUM_CH-1:0]   rise_det, fall_det, hit, drop, consumed, capture;
  logic                handshake;
  logic [CH_W-1:0]     ch_inc, scan_base, grant_ch;
  logic                grant_found;

  assign rise_det  = data_in & ~prev_q & rise_en;
  assign fall_det  = ~data_in & prev_q & fall_en;
  assign hit       = {NUM_CH{en}} & (rise_det | fall_det);

  assign handshake = (state_q == ST_FULL) && evt.evt_ready;
  assign ch_inc    = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);
  // On a handshake the scan already starts from the pointer value being written.
  assign scan_base = handshake ? ch_inc : ptr_q;

  always_comb begin
    logic [CH_W:0] idx;
    grant_found = 1'b0;
    grant_ch    = '0;
    idx         = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = {1'b0, scan_base} + (CH_W+1)'(k);
      if (idx >= (CH_W+1)'(NUM_CH)) idx = idx - (CH_W+1)'(NUM_CH);
      if (!grant_found && pend_q[idx[CH_W-1:0]]) begin
        grant_found = 1'b1;
        grant_ch    = idx[CH_W-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    rise_out_d = rise_out_q;
    ptr_d      = ptr_q;
    consumed   = '0;
    if (handshake) begin
      ptr_d   = ch_inc;
      state_d = ST_EMPTY;
    end
    if (((state_q == ST_EMPTY) || handshake) && grant_found) begin
      state_d            = ST_FULL;
      ch_d               = grant_ch;
      rise_out_d         = pol_q[grant_ch];
      consumed[grant_ch] = 1'b1;
    end
  end

  // A slot being granted this cycle is free to take a new event; otherwise the oldest wins.
  assign capture = hit & (~pend_q | consumed);
  assign drop    = hit & pend_q & ~consumed;
  assign pend_d  = (pend_q & ~consumed) | hit;
  assign pol_d   = (capture & rise_det) | (~capture & pol_q);

  always_comb begin
    ovf_d = ovf_q | drop;
    cnt_d = cnt_q;
    if ((|drop) && (cnt_q != '1)) cnt_d = cnt_q + DROP_W'(1);
    if (clr_ovf) begin
      ovf_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_EMPTY;
      prev_q     <= '0;
      pend_q     <= '0;
      pol_q      <= '0;
      ovf_q      <= '0;
      ch_q       <= '0;
      ptr_q      <= '0;
      rise_out_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= data_in;
      pend_q     <= pend_d;
      pol_q      <= pol_d;
      ovf_q      <= ovf_d;
      ch_q       <= ch_d;
      ptr_q      <= ptr_d;
      rise_out_q <= rise_out_d;
      cnt_q      <= cnt_d;
    end
  end

  assign evt.evt_valid = (state_q == ST_FULL);
  assign evt.evt_ch    = ch_q;
  assign evt.evt_rise  = rise_out_q;
  assign overflow      = ovf_q;
  assign drop_cnt      = cnt_q;

endmodule
